fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 114 +++++++++++
 tb/tb_fetch_stage.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: small program memory loaded while IDLE, then one
// registered fetch per cycle in RUN with stall/flush/halt control.
module fetch_stage #(
  parameter logic [8:0] NOP   = 9'h000,
  parameter int         DEPTH = 1024
) (
  input  logic        CLK,
  input  logic        init_n,
  input  logic        start,
  input  logic [9:0]  pc,
  input  logic        halt_in,
  input  logic        stall,
  input  logic        flush,
  input  logic        prog_we,
  input  logic [9:0]  prog_addr,
  input  logic [8:0]  prog_data,
  output logic [8:0]  instr,
  output logic [9:0]  instr_pc,
  output logic        valid,
  output logic        halt_out,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [8:0]  instr_q, instr_d;
  logic [9:0]  instr_pc_q, instr_pc_d;
  logic        valid_q, valid_d;
  logic        halt_q, halt_d;
  logic [15:0] cnt_q, cnt_d;
  logic        ready_q;
  logic        mem_we;

  logic [8:0]  mem [DEPTH];

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    halt_d     = halt_q;
    cnt_d      = cnt_q;
    mem_we     = 1'b0;
    case (state_q)
      IDLE: begin
        // ready_q masks the first edge after reset release
        if (ready_q) begin
          mem_we = prog_we;
          if (start) state_d = RUN;
        end
      end
      RUN: begin
        if (halt_in) begin
          state_d = HALTED;
          valid_d = 1'b0;
          instr_d = NOP;
          halt_d  = 1'b1;
        end else if (flush) begin
          valid_d    = 1'b0;
          instr_d    = NOP;
          instr_pc_d = pc;
        end else if (!stall) begin
          instr_d    = mem[pc];
          instr_pc_d = pc;
          valid_d    = 1'b1;
          if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        end
      end
      HALTED: ;
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        instr_d = NOP;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge init_n) begin
    if (!init_n) begin
      state_q    <= IDLE;
      instr_q    <= NOP;
      instr_pc_q <= 10'd0;
      valid_q    <= 1'b0;
      halt_q     <= 1'b0;
      cnt_q      <= 16'd0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      halt_q     <= halt_d;
      cnt_q      <= cnt_d;
      ready_q    <= 1'b1;
    end
  end

  // Program memory has no reset: contents survive init_n.
  always_ff @(posedge CLK) begin
    if (mem_we) mem[prog_addr] <= prog_data;
  end

  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign valid       = valid_q;
  assign halt_out    = halt_q;
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed + randomized bench for fetch_stage against a behavioural model.
module tb_fetch_stage;
  logic        CLK = 1'b0, init_n = 1'b0, start = 1'b0, halt_in = 1'b0;
  logic        stall = 1'b0, flush = 1'b0, prog_we = 1'b0;
  logic [9:0]  pc = 10'd0, prog_addr = 10'd0;
  logic [8:0]  prog_data = 9'd0;
  logic [8:0]  instr;
  logic [9:0]  instr_pc;
  logic        valid, halt_out;
  logic [15:0] fetch_count;
  int tests = 0, fails = 0;

  fetch_stage dut (
    .CLK(CLK), .init_n(init_n), .start(start), .pc(pc), .halt_in(halt_in),
    .stall(stall), .flush(flush), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .instr(instr), .instr_pc(instr_pc), .valid(valid),
    .halt_out(halt_out), .fetch_count(fetch_count)
  );

  always #5 CLK = ~CLK;

  // Reference model
  typedef enum {M_IDLE, M_RUN, M_HALT} mode_e;
  mode_e      mode;
  bit         armed;
  logic [8:0] ref_mem [1024];
  logic [8:0] e_instr;
  logic [9:0] e_pc;
  logic       e_valid, e_halt;
  int         e_cnt;

  task automatic model_reset();
    mode = M_IDLE; armed = 1'b0;
    e_instr = 9'h000; e_pc = 10'd0; e_valid = 1'b0; e_halt = 1'b0; e_cnt = 0;
  endtask

  task automatic model_edge();
    if (!armed) armed = 1'b1;
    else case (mode)
      M_IDLE: begin
        if (prog_we) ref_mem[prog_addr] = prog_data;
        if (start) mode = M_RUN;
      end
      M_RUN: begin
        if (halt_in) begin
          mode = M_HALT; e_valid = 1'b0; e_instr = 9'h000; e_halt = 1'b1;
        end else if (flush) begin
          e_valid = 1'b0; e_instr = 9'h000; e_pc = pc;
        end else if (!stall) begin
          e_instr = ref_mem[pc]; e_pc = pc; e_valid = 1'b1;
          e_cnt = (e_cnt >= 65535) ? 65535 : e_cnt + 1;
        end
      end
      default: ;
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("instr",       32'(instr),       32'(e_instr));
    chk("instr_pc",    32'(instr_pc),    32'(e_pc));
    chk("valid",       32'(valid),       32'(e_valid));
    chk("halt_out",    32'(halt_out),    32'(e_halt));
    chk("fetch_count", 32'(fetch_count), 32'(e_cnt));
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    chk_all();
  endtask

  // One edge, then a reset pulse that starts and ends between edges.
  task automatic reset_between_edges();
    step();
    #2 init_n = 1'b0;
    model_reset();
    #1 chk_all();
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_cnt",   32'(fetch_count), 32'd0);
    #2 init_n = 1'b1;
  endtask

  initial begin
    #1 model_reset();
    chk_all();
    #2 init_n = 1'b1;
    step();

    for (int a = 0; a < 1024; a++) begin
      prog_we = 1'b1; prog_addr = 10'(a);
      prog_data = (a == 0) ? 9'h011 : (a == 1) ? 9'h022 : (a == 2) ? 9'h033 : 9'($urandom);
      step();
    end
    prog_we = 1'b0;

    start = 1'b1; step(); start = 1'b0;
    pc = 10'd0; step(); chk("f0", 32'(instr), 32'h011);
    pc = 10'd1; step(); chk("f1", 32'(instr), 32'h022);
    pc = 10'd2; step(); chk("f2", 32'(instr), 32'h033);
    chk("cnt3", 32'(fetch_count), 32'd3);

    prog_we = 1'b1; prog_addr = 10'd7; prog_data = ~ref_mem[7]; pc = 10'd5; step();
    prog_we = 1'b0;
    stall = 1'b1;
    repeat (3) begin
      pc = 10'($urandom); step();
      chk("stall_pc", 32'(instr_pc), 32'd5);
      chk("stall_cnt", 32'(fetch_count), 32'd4);
    end
    stall = 1'b0; pc = 10'd6; step(); chk("unstall_pc", 32'(instr_pc), 32'd6);
    pc = 10'd7; step();

    flush = 1'b1; stall = 1'b1; pc = 10'd40; step();
    chk("flush_valid", 32'(valid), 32'd0);
    chk("flush_instr", 32'(instr), 32'h000);
    chk("flush_pc", 32'(instr_pc), 32'd40);
    chk("flush_cnt", 32'(fetch_count), 32'd6);
    flush = 1'b0; stall = 1'b0;

    repeat (300) begin
      pc = 10'($urandom); stall = ($urandom % 4 == 0); flush = ($urandom % 8 == 0);
      prog_we = 1'($urandom); prog_addr = 10'($urandom); prog_data = 9'($urandom);
      start = 1'($urandom);
      step();
    end
    stall = 1'b0; flush = 1'b0; prog_we = 1'b0; start = 1'b0;

    halt_in = 1'b1; flush = 1'b1; stall = 1'b1; step();
    chk("halt_out", 32'(halt_out), 32'd1);
    chk("halt_valid", 32'(valid), 32'd0);
    halt_in = 1'b0; flush = 1'b0; stall = 1'b0;
    start = 1'b1; prog_we = 1'b1; prog_addr = 10'd0; prog_data = 9'h1ff;
    repeat (3) step();
    start = 1'b0; prog_we = 1'b0;
    chk("halt_sticky", 32'(halt_out), 32'd1);

    reset_between_edges();
    step();
    pc = 10'd0; step(); chk("no_start_valid", 32'(valid), 32'd0);
    start = 1'b1; step(); start = 1'b0;
    pc = 10'd0; step(); chk("mem0_kept", 32'(instr), 32'h011);

    prog_we = 1'b1; prog_addr = 10'd1; prog_data = 9'h1aa; pc = 10'd2; step();
    prog_we = 1'b0; pc = 10'd3;
    reset_between_edges();
    step();
    start = 1'b1; step(); start = 1'b0;
    pc = 10'd1; step(); chk("mem1_kept", 32'(instr), 32'h022);

    for (int i = 0; i < 65533; i++) begin
      pc = 10'($urandom % 3); step();
    end
    chk("cnt_fffe", 32'(fetch_count), 32'hFFFE);
    step(); chk("cnt_ffff", 32'(fetch_count), 32'hFFFF);
    step(); chk("cnt_sat", 32'(fetch_count), 32'hFFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
